line_fill_buf: RTL
==================

// Module: line_fill_buf
// PURPOSE
//  Parametrised D-cache line-fill buffer; successor of the fixed 16x32-bit return buffer.
//  Collects AXI read beats of a missed line into a LINE_BYTES register and supports critical-word-first wrap order.
//  On a store miss, merges the CPU store (byte strobes) into the target word while filling.
//  Early-forwards the target word to the pipeline, checks r_last framing, then hands the full line to the cache data RAM.
// PARAMETERS
//  LINE_BYTES  64  cache line size in bytes; power of 2, >= BUS_WIDTH/8
//  BUS_WIDTH   32  AXI read-data width in bits; one of 32/64/128
//  WRAP        1   1: first beat = beat holding target word, index wraps mod BEATS; 0: incrementing from beat 0
//  derived: BEATS = LINE_BYTES*8/BUS_WIDTH; WPB (words per beat) = BUS_WIDTH/32
// PORTS
//  clk         in   1                 clock, all state on rising edge
//  rstn        in   1                 asynchronous active-low reset
//  start       in   1                 fill request; sampled only in IDLE
//  start_addr  in   32                miss address; [log2(LINE_BYTES)-1:2] selects target word
//  start_op    in   1                 0 = load miss, 1 = store miss
//  start_wstrb in   4                 store byte strobes (any pattern, incl. 0000)
//  start_wdata in   32                store data
//  r_data      in   BUS_WIDTH         AXI read data beat
//  r_valid     in   1                 beat valid
//  r_last      in   1                 last beat of burst
//  r_ready     out  1                 buffer accepts beat
//  busy        out  1                 state != IDLE
//  word_valid  out  1                 1-cycle pulse: target word arrived
//  word_data   out  32                target word after store merge; held until next start
//  line_data   out  LINE_BYTES*8      assembled line, word 0 in bits [31:0]
//  fill_done   out  1                 1-cycle pulse: line_data complete and stable
//  fill_err    out  1                 sticky per fill: r_last framing error
// BEHAVIOUR
//  Reset (rstn=0, async): state IDLE; beat counter 0; r_ready, busy, word_valid, fill_done, fill_err = 0;
//   word_data = 0; line_data = 0. Reset mid-fill discards the fill; no fill_done pulse follows.
//  States: IDLE -> FILL -> DONE -> IDLE.
//  IDLE: start=1 latches addr/op/wstrb/wdata, clears cnt and fill_err, next cycle FILL. start ignored elsewhere.
//  FILL: r_ready=1 (registered, asserted the cycle after entry). Beat accepted when r_valid&&r_ready.
//   slot = (first_beat + cnt) mod BEATS; first_beat = WRAP ? target_word/WPB : 0.
//   Beat written to line_data[slot*BUS_WIDTH +: BUS_WIDTH]; slots not yet written keep old contents.
//   If slot holds target word and op=1: per byte b, byte = wstrb[b] ? wdata byte : r_data byte. op=0: no merge.
//   Same edge: word_data <= merged target word; word_valid pulses next cycle.
//   cnt increments per accepted beat. On accepted beat with cnt==BEATS-1: r_ready drops next cycle, -> DONE;
//   fill_err set if r_last=0 on that beat.
//   r_last=1 on beat with cnt<BEATS-1: fill_err=1, beat still stored, -> DONE (remaining slots stale).
//   r_valid gaps of any length allowed; no timeout.
//  DONE: fill_done=1 for exactly one cycle, then IDLE. line_data, word_data, fill_err hold until next start.
//  Latency: final beat at edge N -> fill_done high in cycle N+1; start in IDLE -> r_ready high 2 cycles later.
//  BEATS=1 legal: single beat completes the fill.
// TESTING
//  1. Defaults, WRAP=0, load miss addr 0x100, 16 beats 0x00..0x0F, r_last on 16th -> line word i = i,
//     fill_done 1 cycle after beat 16, fill_err=0, word_valid after beat 1, word_data 0x0.
//  2. WRAP=1, store miss addr 0x128, wstrb 0011, wdata 0xAAAA5555, beats D0..D15 = 0xC0DE00k0 (k=0..15)
//     -> first beat lands in slot 10; word 10 = 0xC0DE5555; slot 9 = D15; word_valid after first beat.
//  3. BUS_WIDTH=64, LINE_BYTES=32, WRAP=1, addr 0x14 -> 4 beats, first beat in slot 2, last in slot 1;
//     word_data = upper 32 bits of first beat.
//  4. Early r_last on beat 5 of 16 -> fill_err=1, fill_done pulses, r_ready low; next start clears fill_err.
//  5. Missing r_last on beat 16 -> fill_err=1, fill_done=1; random r_valid gaps (0-5 cycles) give same line.
//  6. rstn low at beat 7 -> all outputs 0 immediately, no fill_done; new start after release fills correctly.

Source files
------------

// File: rtl/line_fill_buf.sv
// -----------------------------------------------------------------------------
// line_fill_buf
//   D-cache line-fill buffer. It collects the AXI read beats of a missed line
//   into a LINE_BYTES-wide register, optionally in critical-word-first (wrap)
//   order. On a store miss it merges the CPU store into the target word while
//   filling. The target word is forwarded early, r_last framing is checked,
//   and the complete line is then presented to the cache data RAM.
//
// Ports
//   clk, rstn            clock (rising edge), asynchronous active-low reset
//   start                fill request, sampled only while idle
//   start_addr           miss address; word index = addr[log2(LINE_BYTES)-1:2]
//   start_op             0 = load miss, 1 = store miss
//   start_wstrb/_wdata   store byte strobes and store data
//   r_data/r_valid/r_last/r_ready   AXI read-data channel
//   busy                 a fill is in progress (FILL or DONE)
//   word_valid           1-cycle pulse: target word has arrived
//   word_data            target word after store merge, held until overwritten
//   line_data            assembled line, word 0 in bits [31:0]
//   fill_done            1-cycle pulse: line_data complete and stable
//   fill_err             sticky per fill: r_last framing error
// -----------------------------------------------------------------------------
module line_fill_buf #(
   parameter int LINE_BYTES = 64,
   parameter int BUS_WIDTH  = 32,
   parameter bit WRAP       = 1'b1
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    start,
   input  logic [31:0]             start_addr,
   input  logic                    start_op,
   input  logic [3:0]              start_wstrb,
   input  logic [31:0]             start_wdata,
   input  logic [BUS_WIDTH-1:0]    r_data,
   input  logic                    r_valid,
   input  logic                    r_last,
   output logic                    r_ready,
   output logic                    busy,
   output logic                    word_valid,
   output logic [31:0]             word_data,
   output logic [LINE_BYTES*8-1:0] line_data,
   output logic                    fill_done,
   output logic                    fill_err
);

   localparam int BEATS    = LINE_BYTES * 8 / BUS_WIDTH;
   localparam int WPB      = BUS_WIDTH / 32;
   localparam int WORDS    = LINE_BYTES / 4;
   localparam int CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int WIDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int LANE_SH  = $clog2(WPB);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [CNT_W-1:0]    r_cnt;
   logic [WIDX_W-1:0]   r_tword;
   logic                r_op;
   logic [3:0]          r_wstrb;
   logic [31:0]         r_wdata;
   logic                r_rdy;
   logic                r_wv;
   logic [31:0]         r_word;
   logic [LINE_BYTES*8-1:0] r_line;
   logic                r_err;

   logic [WIDX_W-1:0]   w_tword_in;
   logic [CNT_W-1:0]    w_first;
   logic [CNT_W-1:0]    w_tbeat;
   logic [31:0]         w_sum;
   logic [CNT_W-1:0]    w_slot;
   logic [31:0]         w_lane;
   logic                w_hit;
   logic                w_acc;
   logic                w_is_last;
   logic                w_fin;
   logic [BUS_WIDTH-1:0] w_beat;
   logic [31:0]         w_tgt;

   // Byte-wise store merge; a load miss passes the returned word through.
   function automatic logic [31:0] f_merge(input logic [31:0] rd, input logic op,
                                           input logic [3:0] strb, input logic [31:0] wd);
      logic [31:0] res;
      res = rd;
      for (int b = 0; b < 4; b++) begin
         if (op && strb[b]) res[8*b +: 8] = wd[8*b +: 8];
      end
      return res;
   endfunction

   // Word index within the line; the full address is shifted and masked so the
   // field width follows LINE_BYTES.
   assign w_tword_in = WIDX_W'((start_addr >> 2) & 32'(WORDS - 1));

   assign w_tbeat   = CNT_W'(32'(r_tword) >> LANE_SH);
   assign w_first   = WRAP ? w_tbeat : '0;
   // BEATS is a power of two, so masking implements the modulo wrap.
   assign w_sum     = 32'(w_first) + 32'(r_cnt);
   assign w_slot    = CNT_W'(w_sum & 32'(BEATS - 1));
   assign w_lane    = 32'(r_tword) & 32'(WPB - 1);
   assign w_hit     = (w_slot == w_tbeat);
   assign w_acc     = r_valid && r_rdy;
   assign w_is_last = (r_cnt == CNT_W'(BEATS - 1));
   // A fill ends on the last expected beat or on an early r_last.
   assign w_fin     = w_acc && (w_is_last || r_last);

   always_comb begin
      w_beat = r_data;
      w_tgt  = '0;
      for (int l = 0; l < WPB; l++) begin
         if (w_hit && (32'(l) == w_lane)) begin
            w_tgt                = f_merge(r_data[l*32 +: 32], r_op, r_wstrb, r_wdata);
            w_beat[l*32 +: 32]   = w_tgt;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_FILL;
         S_FILL:  if (w_fin) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt   <= '0;
         r_tword <= '0;
         r_op    <= 1'b0;
         r_wstrb <= '0;
         r_wdata <= '0;
         r_rdy   <= 1'b0;
         r_wv    <= 1'b0;
         r_word  <= '0;
         r_line  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_wv  <= 1'b0;
         r_rdy <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_tword <= w_tword_in;
                  r_op    <= start_op;
                  r_wstrb <= start_wstrb;
                  r_wdata <= start_wdata;
                  r_cnt   <= '0;
                  r_err   <= 1'b0;
               end
            end
            S_FILL: begin
               // Ready is registered: low on the entry cycle, low again after the final beat.
               r_rdy <= !w_fin;
               if (w_acc) begin
                  for (int s = 0; s < BEATS; s++) begin
                     if (w_slot == CNT_W'(s)) r_line[s*BUS_WIDTH +: BUS_WIDTH] <= w_beat;
                  end
                  if (w_hit) begin
                     r_word <= w_tgt;
                     r_wv   <= 1'b1;
                  end
                  r_cnt <= r_cnt + 1'b1;
                  if (w_fin && (r_last != w_is_last)) r_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign r_ready    = r_rdy;
   assign busy       = (r_state != S_IDLE);
   assign word_valid = r_wv;
   assign word_data  = r_word;
   assign line_data  = r_line;
   assign fill_done  = (r_state == S_DONE);
   assign fill_err   = r_err;

endmodule
